// File: rtl/bit_serializer.sv
// bit_serializer: parallel word in over valid/ready, one bit per clk out on sout.
// Ports: clk, rst (sync, active-low), load_valid/load_data/load_ready in,
//        sout/sout_valid/last/busy out (registered); sout idles at 0.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int GAP       = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             last,
  output logic             busy
);

  localparam int BW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BLAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BPEN  = BW'(WIDTH - 2);
  localparam logic [3:0] GLOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam bit HAS_GAP = (GAP > 0);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_GAP
  } state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  sr, sr_n;
  logic [BW-1:0]     bcnt, bcnt_n;
  logic [3:0]        gcnt, gcnt_n;
  logic              sout_n, valid_n, last_n, busy_n;
  logic              accept, final_bit;

  function automatic logic head(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d[WIDTH-1] : d[0];
  endfunction

  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? (d << 1) : (d >> 1);
  endfunction

  // sout is a register, so the first bit is taken straight from
  // load_data at the accept edge and sr keeps only the bits still to go.
  assign final_bit  = (state == S_SHIFT) && (bcnt == BLAST);
  assign load_ready = rst &&
                      ((state == S_IDLE) || (final_bit && !HAS_GAP));
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    bcnt_n  = bcnt;
    gcnt_n  = gcnt;
    sout_n  = 1'b0;
    valid_n = 1'b0;
    last_n  = 1'b0;
    busy_n  = 1'b0;
    if (accept) begin
      state_n = S_SHIFT;
      sr_n    = tail(load_data);
      bcnt_n  = '0;
      sout_n  = head(load_data);
      valid_n = 1'b1;
      busy_n  = 1'b1;
    end else begin
      case (state)
        S_SHIFT: begin
          if (final_bit) begin
            if (HAS_GAP) begin
              state_n = S_GAP;
              gcnt_n  = GLOAD;
              busy_n  = 1'b1;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            sout_n  = head(sr);
            sr_n    = tail(sr);
            bcnt_n  = bcnt + 1'b1;
            valid_n = 1'b1;
            busy_n  = 1'b1;
            last_n  = (bcnt == BPEN);
          end
        end
        S_GAP: begin
          if (gcnt == 4'd0) begin
            state_n = S_IDLE;
          end else begin
            gcnt_n = gcnt - 4'd1;
            busy_n = 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= S_IDLE;
      sr         <= '0;
      bcnt       <= '0;
      gcnt       <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      last       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      sr         <= sr_n;
      bcnt       <= bcnt_n;
      gcnt       <= gcnt_n;
      sout       <= sout_n;
      sout_valid <= valid_n;
      last       <= last_n;
      busy       <= busy_n;
    end
  end

endmodule
